// File: rtl/neuron_mac_writeback.sv
// Multiply-accumulate and writeback stage for one neural-network layer: aligns control with RAM read data,
// accumulates a saturating dot product, and writes each neuron result. Define RELU_EN to zero negative results.
module neuron_mac_writeback #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int ACC_W     = 20,
    parameter int MEM_LAT   = 1,
    parameter int FRAC_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step_in,
    input  logic              neuron_end_in,
    input  logic              layer_end_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] weight_data,
    input  logic [DATA_W-1:0] neuro_data,
    output logic              neuro_wr_en,
    output logic [ADDR_W-1:0] neuro_wr_addr,
    output logic [DATA_W-1:0] neuro_wr_data,
    output logic              layer_done,
    output logic              busy,
    output logic              sat_flag
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state;

    logic [MEM_LAT-1:0] dl_step;
    logic [MEM_LAT-1:0] dl_nend;
    logic [MEM_LAT-1:0] dl_lend;
    logic [ADDR_W-1:0]  dl_addr [MEM_LAT];

    logic                     accept;
    logic                     m_valid;
    logic                     m_nend;
    logic                     m_lend;
    logic [ADDR_W-1:0]        m_addr;
    logic                     first;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]    sum_wide;
    logic                     acc_ovf;
    logic                     out_clamp;
    logic [DATA_W-1:0]        out_sat;
    logic [DATA_W-1:0]        out_data;

    // A step arriving together with start already belongs to the new layer.
    assign accept = step_in && (start || (state == RUN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_step <= '0;
            dl_nend <= '0;
            dl_lend <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                dl_addr[i] <= '0;
            end
        end else begin
            dl_step[0] <= accept;
            dl_nend[0] <= accept && (neuron_end_in || layer_end_in);
            dl_lend[0] <= accept && layer_end_in;
            dl_addr[0] <= wr_addr_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                dl_step[i] <= start ? 1'b0 : dl_step[i-1];
                dl_nend[i] <= start ? 1'b0 : dl_nend[i-1];
                dl_lend[i] <= start ? 1'b0 : dl_lend[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    // A term sitting in the data stage while start is high is dropped.
    assign m_valid = dl_step[MEM_LAT-1] && (state == RUN) && !start;
    assign m_nend  = dl_nend[MEM_LAT-1];
    assign m_lend  = dl_lend[MEM_LAT-1];
    assign m_addr  = dl_addr[MEM_LAT-1];

    always_comb begin
        prod      = $signed(weight_data) * $signed(neuro_data);
        acc_base  = first ? '0 : acc;
        sum_wide  = {acc_base[ACC_W-1], acc_base}
                  + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        acc_ovf   = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
        acc_next  = acc_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
        shifted   = acc_next >>> FRAC_BITS;
        out_clamp = !((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]));
        out_sat   = out_clamp ? (shifted[ACC_W-1] ? OUT_MIN : OUT_MAX) : shifted[DATA_W-1:0];
        out_data  = out_sat;
`ifdef RELU_EN
        if (out_sat[DATA_W-1]) begin
            out_data = '0;
        end
`endif
    end

    // Control FSM, accumulator and registered writeback; the state leaves RUN at the end of the final write cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            first         <= 1'b0;
            acc           <= '0;
            sat_flag      <= 1'b0;
            neuro_wr_en   <= 1'b0;
            neuro_wr_addr <= '0;
            neuro_wr_data <= '0;
            layer_done    <= 1'b0;
        end else begin
            neuro_wr_en <= 1'b0;
            layer_done  <= 1'b0;
            if (start) begin
                state    <= RUN;
                first    <= 1'b1;
                acc      <= '0;
                sat_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        if (layer_done) begin
                            state <= IDLE;
                        end
                        if (m_valid) begin
                            acc   <= acc_next;
                            first <= m_nend;
                            if (acc_ovf || (m_nend && out_clamp)) begin
                                sat_flag <= 1'b1;
                            end
                            if (m_nend) begin
                                neuro_wr_en   <= 1'b1;
                                neuro_wr_addr <= m_addr;
                                neuro_wr_data <= out_data;
                                layer_done    <= m_lend;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RUN);

endmodule
